// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button debouncer with press/release/long-press pulses and a press counter.
// Raw key_n is synchronised, then a 4-state FSM accepts a level only after DEBOUNCE_CYCLES+1 agreeing samples.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int COUNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_n,
    output logic               key_level,
    output logic               key_press,
    output logic               key_release,
    output logic               key_long,
    output logic [COUNT_W-1:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_PRESS_CYCLES - 2);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sync1;
    logic               sync2;
    logic               key_s;
    logic [DW-1:0]      db_cnt;
    logic [DW-1:0]      db_nxt;
    logic [HW-1:0]      hold_cnt;
    logic [HW-1:0]      hold_nxt;
    logic               long_flag;
    logic               flag_nxt;
    logic               level_nxt;
    logic               press_nxt;
    logic               rel_nxt;
    logic               long_nxt;
    logic [COUNT_W-1:0] count_nxt;

    // Synchroniser idles at 1 so a reset looks like a released key.
    assign key_s = ~sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state       <= RELEASED;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            long_flag   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            press_count <= '0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            state       <= state_nxt;
            db_cnt      <= db_nxt;
            hold_cnt    <= hold_nxt;
            long_flag   <= flag_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= rel_nxt;
            key_long    <= long_nxt;
            press_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        db_nxt    = db_cnt;
        hold_nxt  = hold_cnt;
        flag_nxt  = long_flag;
        level_nxt = key_level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        long_nxt  = 1'b0;
        count_nxt = press_count;
        case (state)
            RELEASED: begin
                if (key_s) begin
                    state_nxt = PRESS_WAIT;
                    db_nxt    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_nxt = RELEASED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                    count_nxt = press_count + COUNT_W'(1);
                    hold_nxt  = '0;
                    flag_nxt  = 1'b0;
                end else begin
                    db_nxt = db_cnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    state_nxt = RELEASE_WAIT;
                    db_nxt    = '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + HW'(1);
                    // Fire on the edge that brings the hold count to its last value.
                    if (hold_cnt == HOLD_PRE && !long_flag) begin
                        long_nxt = 1'b1;
                        flag_nxt = 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_nxt = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = RELEASED;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                    hold_nxt  = '0;
                    flag_nxt  = 1'b0;
                end else begin
                    db_nxt = db_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
            end
        endcase
    end

    a_press_release_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(key_press && key_release));
    a_press_single : assert property (@(posedge clk) disable iff (!rst_n)
        key_press |=> !key_press);
    a_release_single : assert property (@(posedge clk) disable iff (!rst_n)
        key_release |=> !key_release);
    a_long_single : assert property (@(posedge clk) disable iff (!rst_n)
        key_long |=> !key_long);

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce with a run-length behavioural model.
module tb_key_debounce;

    localparam int D = 4;
    localparam int L = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_n;
    logic         key_level;
    logic         key_press;
    logic         key_release;
    logic         key_long;
    logic [W-1:0] press_count;

    int nvec  = 0;
    int nfail = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .COUNT_W          (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs as the DUT saw them at the most recent rising edge.
    logic smp_kn;
    logic smp_rn;
    logic seen = 1'b0;
    always @(posedge clk) begin
        smp_kn <= key_n;
        smp_rn <= rst_n;
        seen   <= 1'b1;
    end

    // Model: a level flips once D+1 consecutive synchronised samples disagree with it.
    logic kq[$];
    int   m_run;
    int   m_hold;
    int   m_count;
    logic m_level;
    logic m_press;
    logic m_rel;
    logic m_long;
    logic ks;

    initial begin
        kq      = '{1'b1, 1'b1};
        m_run   = 0;
        m_hold  = 0;
        m_count = 0;
        m_level = 1'b0;
        forever begin
            @(negedge clk);
            if (seen) begin
                m_press = 1'b0;
                m_rel   = 1'b0;
                m_long  = 1'b0;
                if (!smp_rn) begin
                    kq      = '{1'b1, 1'b1};
                    m_run   = 0;
                    m_hold  = 0;
                    m_count = 0;
                    m_level = 1'b0;
                end else begin
                    ks = !kq[0];
                    kq.push_back(smp_kn);
                    void'(kq.pop_front());
                    if (ks != m_level) begin
                        m_run++;
                        if (m_run == D + 1) begin
                            m_level = ks;
                            m_run   = 0;
                            m_hold  = 0;
                            if (ks) begin
                                m_press = 1'b1;
                                m_count = (m_count + 1) % (1 << W);
                            end else begin
                                m_rel = 1'b1;
                            end
                        end
                    end else begin
                        if (m_level && m_run == 0 && m_hold < L - 1) begin
                            m_hold++;
                            if (m_hold == L - 1) m_long = 1'b1;
                        end
                        m_run = 0;
                    end
                end
                chk("key_level",   32'(key_level),   32'(m_level));
                chk("key_press",   32'(key_press),   32'(m_press));
                chk("key_release", 32'(key_release), 32'(m_rel));
                chk("key_long",    32'(key_long),    32'(m_long));
                chk("press_count", 32'(press_count), 32'(m_count));
            end
        end
    end

    task automatic step(input logic kn, input logic rn);
        key_n = kn;
        rst_n = rn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic kn);
        step(kn, 1'b0);
        step(kn, 1'b0);
    endtask

    initial begin
        key_n = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);

        do_reset(1'b1);
        chk("rst_level", 32'(key_level),   0);
        chk("rst_count", 32'(press_count), 0);
        chk("rst_press", 32'(key_press),   0);

        // Clean press from edge 10 held 40 cycles, release from edge 50.
        for (int e = 1; e <= 60; e++) begin
            step((e >= 10 && e < 50) ? 1'b0 : 1'b1, 1'b1);
            case (e)
                15: chk("press_e15", 32'(key_press), 0);
                16: begin
                    chk("press_e16", 32'(key_press),   1);
                    chk("level_e16", 32'(key_level),   1);
                    chk("count_e16", 32'(press_count), 1);
                end
                17: chk("press_e17", 32'(key_press), 0);
                30: chk("long_e30",  32'(key_long), 0);
                31: chk("long_e31",  32'(key_long), 1);
                32: chk("long_e32",  32'(key_long), 0);
                55: chk("rel_e55",   32'(key_release), 0);
                56: begin
                    chk("rel_e56",   32'(key_release), 1);
                    chk("level_e56", 32'(key_level),   0);
                end
                57: chk("rel_e57",   32'(key_release), 0);
                default: ;
            endcase
        end

        // Release glitch of two cycles while pressed.
        do_reset(1'b1);
        for (int e = 1; e <= 40; e++) begin
            step((e == 21 || e == 22) ? 1'b1 : 1'b0, 1'b1);
            if (e == 7) chk("glitch_press_e7", 32'(key_press), 1);
        end
        chk("glitch_level", 32'(key_level),   1);
        chk("glitch_count", 32'(press_count), 1);

        // Three-cycle bounce is rejected.
        do_reset(1'b1);
        for (int e = 1; e <= 15; e++) step((e <= 3) ? 1'b0 : 1'b1, 1'b1);
        chk("bounce_level", 32'(key_level),   0);
        chk("bounce_count", 32'(press_count), 0);

        // Reset while pressed with the key still held.
        do_reset(1'b1);
        for (int e = 1; e <= 10; e++) step(1'b0, 1'b1);
        chk("mid_level_before", 32'(key_level), 1);
        step(1'b0, 1'b0);
        chk("mid_rst_level", 32'(key_level),   0);
        chk("mid_rst_rel",   32'(key_release), 0);
        chk("mid_rst_count", 32'(press_count), 0);
        step(1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, 1'b1);
            if (e == 6) chk("mid_press_e6", 32'(key_press), 0);
            if (e == 7) begin
                chk("mid_press_e7", 32'(key_press),   1);
                chk("mid_count_e7", 32'(press_count), 1);
            end
        end

        // Sixteen presses wrap a 4-bit counter.
        do_reset(1'b1);
        for (int p = 1; p <= 16; p++) begin
            for (int e = 0; e < 16; e++) step((e < 8) ? 1'b0 : 1'b1, 1'b1);
            if (p == 15) chk("wrap_15", 32'(press_count), 15);
            if (p == 16) chk("wrap_16", 32'(press_count), 0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable cycles needed to accept a level change (20 ms at 50 MHz); legal values are >= 2.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 50000000, hold cycles after an accepted press before key_long fires; legal values are >= 2.
REQ-003 SHALL have parameter COUNT_W, default 8, width of press_count.
REQ-004 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port key_n  input  1  asynchronous raw board push-button; 0 means pressed.
REQ-007 SHALL have port key_level  output  1  debounced pressed level; 1 means pressed.
REQ-008 SHALL have port key_press  output  1  one-cycle pulse on each accepted press.
REQ-009 SHALL have port key_release  output  1  one-cycle pulse on each accepted release.
REQ-010 SHALL have port key_long  output  1  one-cycle pulse, at most once per press.
REQ-011 SHALL have port press_count  output  COUNT_W  running count of accepted presses.

Function
REQ-012 SHALL pass key_n through a 2-flop synchronizer whose flops reset to 1; key_s is the inverse of the second flop.
REQ-013 SHALL implement a 4-state FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-014 SHALL have a debounce counter sized to hold DEBOUNCE_CYCLES-1, and a hold counter sized to hold LONG_PRESS_CYCLES-1.
REQ-015 In RELEASED with key_s=1, SHALL go to PRESS_WAIT and clear the debounce counter.
REQ-016 In PRESS_WAIT with key_s=0, SHALL return to RELEASED; this is a bounce, so no pulse and no count change.
REQ-017 In PRESS_WAIT with key_s=1 and debounce counter == DEBOUNCE_CYCLES-1, SHALL go to PRESSED; otherwise the counter increments.
REQ-018 On entry to PRESSED, in the same edge: key_level<=1, key_press<=1 for exactly one cycle, press_count increments modulo 2^COUNT_W, hold counter clears.
REQ-019 Timing: if edge N is the first edge sampling key_n=0 and key_n stays 0, key_press SHALL be high in the cycle after edge N+DEBOUNCE_CYCLES+2.
REQ-020 In PRESSED, the hold counter SHALL increment each cycle and saturate at LONG_PRESS_CYCLES-1.
REQ-021 The edge at which the hold counter equals LONG_PRESS_CYCLES-1 for the first time in this press SHALL pulse key_long once; a per-press flag suppresses repeats.
REQ-022 In PRESSED with key_s=0, SHALL go to RELEASE_WAIT and clear the debounce counter; the hold counter pauses.
REQ-023 In RELEASE_WAIT with key_s=1, SHALL return to PRESSED with no key_press and no count change; the hold counter resumes.
REQ-024 In RELEASE_WAIT with key_s=0 and debounce counter == DEBOUNCE_CYCLES-1, SHALL go to RELEASED: key_level<=0, key_release pulses one cycle, hold counter and long flag clear.
REQ-025 Release latency SHALL be symmetric with press latency (DEBOUNCE_CYCLES+2 edges after the first sampled 1).
REQ-026 key_press, key_release and key_long SHALL never be high in two consecutive cycles.
REQ-027 key_press and key_release SHALL never be high together.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 With rst_n=0 at an edge: state<=RELEASED, synchronizer<=1/1, counters<=0, long flag<=0, key_level=key_press=key_release=key_long=0, press_count=0.
REQ-030 Reset SHALL take priority over every FSM transition.
REQ-031 A reset during PRESSED SHALL produce no key_release pulse.
REQ-032 A key held low through reset SHALL be accepted as a new press after reset deasserts, with REQ-019 timing counted from the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, COUNT_W=4)
REQ-033 Clean press: key_n=0 from edge 10, held 40 cycles -> key_press and key_level rise after edge 16; press_count=1; key_long pulses after edge 31; no further pulses while held.
REQ-034 Clean release after that press: key_n=1 from edge 50 -> key_release pulses and key_level falls after edge 56; key_long does not repeat.
REQ-035 Bounce: key_n=0 for 3 cycles then 1 -> no pulses, key_level=0, press_count=0.
REQ-036 Release glitch: while pressed, key_n=1 for 2 cycles then 0 -> no key_release, no extra key_press, key_level stays 1, press_count unchanged.
REQ-037 Wrap: 16 clean presses from reset -> press_count reads 15 after the 15th press and 0 after the 16th.
REQ-038 Reset mid-press: rst_n=0 for 2 cycles while PRESSED with key_n=0 -> all outputs 0 after the reset edge, no key_release; after reset deasserts, key_press fires DEBOUNCE_CYCLES+2 edges later and press_count=1.
